// File: rtl/mario_pkg.sv
// Shared types and constants for the mario core's work-RAM sharing logic.
package mario_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STALL   = 3'd1,
        GRANT   = 3'd2,
        DRAIN   = 3'd3,
        ABORT   = 3'd4,
        WAITLOW = 3'd5
    } hs_arb_state_t;

    // 10 s of continuous pause at 48 MHz
    localparam int DIM_CYCLES_48M = 480_000_000;

    localparam int HS_RAM_AW = 11;
    localparam int HS_RAM_DW = 8;

    // States in which the arbiter itself holds the CPU stalled
    function automatic logic arb_holds_cpu(input hs_arb_state_t s);
        return (s == STALL) || (s == GRANT) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/pause_dim_timer.sv
// Saturating pause-duration counter: counts while paused, clears as soon as
// the pause ends, and raises o_dim once DIM_CYCLES paused cycles have elapsed.
module pause_dim_timer
    import mario_pkg::*;
#(
    parameter int DIM_CYCLES = DIM_CYCLES_48M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_paused,
    output logic o_dim
);

    localparam int CW = $clog2(DIM_CYCLES + 1);
    localparam logic [CW-1:0] DIM_LIMIT = CW'(DIM_CYCLES);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = '0;
        if (i_paused) begin
            cnt_d = (cnt_q == DIM_LIMIT) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_dim = (cnt_q >= DIM_LIMIT);

endmodule

// File: rtl/hs_ram_arbiter.sv
// Work-RAM arbiter between the game CPU and the hiscore engine: stalls the CPU,
// hands the RAM to the hiscore engine, then returns it; also drives video dim.
module hs_ram_arbiter
    import mario_pkg::*;
#(
    parameter int AW          = HS_RAM_AW,
    parameter int DIM_CYCLES  = DIM_CYCLES_48M,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                 I_CLK_48M,
    input  logic                 I_RESETn,
    input  logic                 I_USER_PAUSE,
    input  logic                 I_OSD_PAUSE,
    input  logic                 I_HS_REQ,
    input  logic [AW-1:0]        I_HS_ADDR,
    input  logic [HS_RAM_DW-1:0] I_HS_DIN,
    input  logic                 I_HS_WE,
    input  logic                 I_HS_RD,
    output logic                 O_HS_GNT,
    output logic [HS_RAM_DW-1:0] O_HS_DOUT,
    output logic                 O_HS_RVALID,
    output logic                 O_HS_ABORT,
    input  logic [AW-1:0]        I_CPU_ADDR,
    input  logic [HS_RAM_DW-1:0] I_CPU_DIN,
    input  logic                 I_CPU_WE,
    output logic                 O_CPU_PAUSE,
    input  logic                 I_CPU_PAUSED,
    output logic [AW-1:0]        O_RAM_ADDR,
    output logic [HS_RAM_DW-1:0] O_RAM_DOUT,
    output logic                 O_RAM_WE,
    input  logic [HS_RAM_DW-1:0] I_RAM_DIN,
    output logic                 O_DIM
);

    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

    hs_arb_state_t         state_d, state_q;
    logic [TW-1:0]         tmo_d, tmo_q;
    logic                  pause_d, pause_q;
    logic                  rd_pend_d, rd_pend_q;
    logic [HS_RAM_DW-1:0]  dout_d, dout_q;
    logic                  gnt;

    assign gnt = (state_q == GRANT);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (I_HS_REQ) begin
                    state_d = STALL;
                    tmo_d   = '0;
                end
            end
            STALL: begin
                if (!I_HS_REQ) begin
                    state_d = IDLE;
                end else if (I_CPU_PAUSED) begin
                    state_d = GRANT;
                end else if (tmo_q == ACK_LAST) begin
                    state_d = ABORT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            // A dropped ack during GRANT is ignored: the grant is only released by the engine
            GRANT:   if (!I_HS_REQ) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            ABORT:   state_d = WAITLOW;
            WAITLOW: if (!I_HS_REQ) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pause is computed from the next state so it rises together with STALL
    assign pause_d   = I_USER_PAUSE | I_OSD_PAUSE | arb_holds_cpu(state_d);
    assign rd_pend_d = gnt & I_HS_RD & ~I_HS_WE;
    assign dout_d    = rd_pend_q ? I_RAM_DIN : dout_q;

    always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            pause_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            pause_q   <= pause_d;
            rd_pend_q <= rd_pend_d;
            dout_q    <= dout_d;
        end
    end

    // RAM has one cycle of latency, so read data is forwarded in the valid cycle and held after
    assign O_HS_DOUT   = rd_pend_q ? I_RAM_DIN : dout_q;
    assign O_HS_RVALID = rd_pend_q;
    assign O_HS_GNT    = gnt;
    assign O_HS_ABORT  = (state_q == ABORT);
    assign O_CPU_PAUSE = pause_q;

    assign O_RAM_ADDR = gnt ? I_HS_ADDR : I_CPU_ADDR;
    assign O_RAM_DOUT = gnt ? I_HS_DIN  : I_CPU_DIN;
    assign O_RAM_WE   = gnt ? I_HS_WE   : I_CPU_WE;

    pause_dim_timer #(
        .DIM_CYCLES (DIM_CYCLES)
    ) u_dim_timer (
        .clk      (I_CLK_48M),
        .rst_n    (I_RESETn),
        .i_paused (pause_q),
        .o_dim    (O_DIM)
    );

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed + randomized bench for hs_ram_arbiter with a synchronous RAM model
// and an expected-memory / expected-read-queue reference.
module tb_hs_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        user_pause, osd_pause;
    logic        hs_req, hs_we, hs_rd;
    logic [10:0] hs_addr;
    logic [7:0]  hs_din;
    logic        hs_gnt, hs_rvalid, hs_abort;
    logic [7:0]  hs_dout;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we, cpu_pause, cpu_paused;
    logic [10:0] ram_addr;
    logic [7:0]  ram_dout, ram_din;
    logic        ram_we, dim;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:2047];
    logic [7:0] exp_mem [0:15];
    logic [7:0] exp_q [$];
    logic       paused_last = 1'b0;
    logic       proto_bad = 1'b0;

    hs_ram_arbiter #(
        .AW          (11),
        .DIM_CYCLES  (100),
        .ACK_TIMEOUT (16)
    ) dut (
        .I_CLK_48M    (clk),
        .I_RESETn     (rst_n),
        .I_USER_PAUSE (user_pause),
        .I_OSD_PAUSE  (osd_pause),
        .I_HS_REQ     (hs_req),
        .I_HS_ADDR    (hs_addr),
        .I_HS_DIN     (hs_din),
        .I_HS_WE      (hs_we),
        .I_HS_RD      (hs_rd),
        .O_HS_GNT     (hs_gnt),
        .O_HS_DOUT    (hs_dout),
        .O_HS_RVALID  (hs_rvalid),
        .O_HS_ABORT   (hs_abort),
        .I_CPU_ADDR   (cpu_addr),
        .I_CPU_DIN    (cpu_din),
        .I_CPU_WE     (cpu_we),
        .O_CPU_PAUSE  (cpu_pause),
        .I_CPU_PAUSED (cpu_paused),
        .O_RAM_ADDR   (ram_addr),
        .O_RAM_DOUT   (ram_dout),
        .O_RAM_WE     (ram_we),
        .I_RAM_DIN    (ram_din),
        .O_DIM        (dim)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // synchronous RAM, one cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_dout;
        ram_din <= mem[ram_addr];
    end

    // CPU must not resume while it is being asked to stall
    always @(negedge clk) begin
        if (rst_n && cpu_pause && paused_last && !cpu_paused) proto_bad <= 1'b1;
        paused_last <= cpu_paused;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        while (hs_gnt !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'b0, hs_gnt}, 32'd1);
    endtask

    initial begin
        int         op;
        logic [3:0] a;
        logic [7:0] d;
        logic       exp_wr;

        rst_n = 1'b0;
        user_pause = 0; osd_pause = 0;
        hs_req = 0; hs_we = 0; hs_rd = 0; hs_addr = '0; hs_din = '0;
        cpu_addr = '0; cpu_din = '0; cpu_we = 0; cpu_paused = 0;
        repeat (3) step();
        chk("rst_gnt",    {31'b0, hs_gnt},    0);
        chk("rst_pause",  {31'b0, cpu_pause}, 0);
        chk("rst_rvalid", {31'b0, hs_rvalid}, 0);
        chk("rst_abort",  {31'b0, hs_abort},  0);
        chk("rst_dim",    {31'b0, dim},       0);
        chk("rst_dout",   {24'b0, hs_dout},   0);
        rst_n = 1'b1;
        step();

        // basic grant
        cpu_addr = 11'h2AA; hs_addr = 11'h1A5; hs_req = 1;
        step();
        chk("basic_pause_rise", {31'b0, cpu_pause}, 1);
        chk("basic_gnt_early",  {31'b0, hs_gnt},    0);
        step(); step();
        chk("basic_gnt_noack",  {31'b0, hs_gnt},    0);
        cpu_paused = 1;
        step();
        chk("basic_gnt",      {31'b0, hs_gnt}, 1);
        chk("basic_ram_addr", {21'b0, ram_addr}, 32'h1A5);
        step();
        hs_req = 0;
        step();
        chk("basic_gnt_drop",   {31'b0, hs_gnt},    0);
        chk("basic_drain_pause", {31'b0, cpu_pause}, 1);
        chk("basic_drain_addr", {21'b0, ram_addr}, 32'h2AA);
        step();
        chk("basic_pause_fall", {31'b0, cpu_pause}, 0);
        cpu_paused = 0;

        // CPU owns the RAM: fill 0..15, hiscore strobes must be ignored
        for (int i = 0; i < 28; i++) begin
            a = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            exp_wr = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            cpu_addr = {7'b0, a}; cpu_din = d; cpu_we = exp_wr;
            hs_we = 1; hs_rd = 1; hs_addr = 11'($urandom_range(0, 2047));
            #1;
            chk("cpu_ram_addr", {21'b0, ram_addr}, {28'b0, a});
            chk("cpu_ram_we",   {31'b0, ram_we},   {31'b0, exp_wr});
            chk("cpu_ram_dout", {24'b0, ram_dout}, {24'b0, d});
            if (exp_wr) exp_mem[a] = d;
            step();
            chk("cpu_no_rvalid", {31'b0, hs_rvalid}, 0);
        end
        cpu_we = 0; hs_we = 0; hs_rd = 0;

        // directed write then read while granted
        hs_req = 1; cpu_paused = 1;
        step();
        wait_gnt("rw_gnt");
        hs_addr = 11'h040; hs_din = 8'h3C; hs_we = 1;
        #1;
        chk("rw_we",   {31'b0, ram_we},   1);
        chk("rw_addr", {21'b0, ram_addr}, 32'h040);
        chk("rw_data", {24'b0, ram_dout}, 32'h3C);
        step();
        chk("rw_no_rvalid", {31'b0, hs_rvalid}, 0);
        hs_we = 0; hs_rd = 1;
        step();
        hs_rd = 0;
        chk("rw_rvalid", {31'b0, hs_rvalid}, 1);
        chk("rw_dout",   {24'b0, hs_dout},   32'h3C);
        step();
        chk("rw_rvalid_pulse", {31'b0, hs_rvalid}, 0);

        // random hiscore traffic against expected memory
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            exp_wr = (op == 1) || (op == 3);
            hs_addr = {7'b0, a}; hs_din = d; hs_we = exp_wr; hs_rd = (op >= 2);
            #1;
            chk("rand_we",   {31'b0, ram_we},   {31'b0, exp_wr});
            chk("rand_addr", {21'b0, ram_addr}, {28'b0, a});
            if (op == 2) exp_q.push_back(exp_mem[a]);
            if (exp_wr) exp_mem[a] = d;
            step();
            if (op == 2) begin
                chk("rand_rvalid", {31'b0, hs_rvalid}, 1);
                chk("rand_dout",   {24'b0, hs_dout},   {24'b0, exp_q.pop_front()});
            end else begin
                chk("rand_no_rvalid", {31'b0, hs_rvalid}, 0);
            end
        end
        hs_we = 0; hs_rd = 0; hs_req = 0;
        step(); step();
        chk("rand_release", {31'b0, cpu_pause}, 0);
        cpu_paused = 0;

        // ack timeout
        hs_req = 1;
        step();
        for (int k = 1; k <= 16; k++) begin
            chk("tmo_no_abort", {31'b0, hs_abort}, 0);
            chk("tmo_no_gnt",   {31'b0, hs_gnt},   0);
            if (k == 1) chk("tmo_pause", {31'b0, cpu_pause}, 1);
            step();
        end
        chk("tmo_abort",       {31'b0, hs_abort},  1);
        chk("tmo_pause_after", {31'b0, cpu_pause}, 0);
        step();
        for (int k = 0; k < 20; k++) begin
            chk("tmo_held_abort", {31'b0, hs_abort},  0);
            chk("tmo_held_pause", {31'b0, cpu_pause}, 0);
            chk("tmo_held_gnt",   {31'b0, hs_gnt},    0);
            step();
        end
        hs_req = 0;
        step();
        hs_req = 1;
        step();
        chk("tmo_rereq", {31'b0, cpu_pause}, 1);
        hs_req = 0;
        step();
        chk("tmo_rereq_drop", {31'b0, cpu_pause}, 0);

        // pre-paused CPU
        user_pause = 1;
        step();
        chk("pre_user_pause", {31'b0, cpu_pause}, 1);
        cpu_paused = 1; hs_req = 1;
        step();
        chk("pre_gnt_c1", {31'b0, hs_gnt}, 0);
        step();
        chk("pre_gnt_c2", {31'b0, hs_gnt}, 1);
        hs_req = 0;
        step();
        chk("pre_gnt_drop", {31'b0, hs_gnt}, 0);
        step();
        chk("pre_pause_kept", {31'b0, cpu_pause}, 1);
        user_pause = 0;
        step();
        chk("pre_pause_off", {31'b0, cpu_pause}, 0);
        cpu_paused = 0;

        // dim after 100 paused cycles
        osd_pause = 1;
        step();
        chk("dim_pause", {31'b0, cpu_pause}, 1);
        repeat (99) step();
        chk("dim_99", {31'b0, dim}, 0);
        step();
        chk("dim_100", {31'b0, dim}, 1);
        repeat (5) step();
        chk("dim_held", {31'b0, dim}, 1);
        osd_pause = 0;
        step(); step();
        chk("dim_clear", {31'b0, dim}, 0);

        // reset in the middle of a grant
        cpu_addr = 11'h155; hs_addr = 11'h0AA; hs_req = 1; cpu_paused = 1;
        step();
        wait_gnt("rst_mid_gnt");
        chk("rst_mid_hs_addr", {21'b0, ram_addr}, 32'h0AA);
        hs_rd = 1;
        step();
        chk("rst_mid_rvalid_pre", {31'b0, hs_rvalid}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_gnt0",    {31'b0, hs_gnt},    0);
        chk("rst_mid_pause0",  {31'b0, cpu_pause}, 0);
        chk("rst_mid_dim0",    {31'b0, dim},       0);
        chk("rst_mid_rvalid0", {31'b0, hs_rvalid}, 0);
        chk("rst_mid_cpuaddr", {21'b0, ram_addr},  32'h155);
        hs_req = 0; hs_rd = 0; cpu_paused = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_rel_gnt",   {31'b0, hs_gnt},    0);
        chk("rst_rel_pause", {31'b0, cpu_pause}, 0);

        chk("cpu_protocol", {31'b0, proto_bad}, 0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the CPU work RAM port between the game CPU and the hiscore save/restore engine.
- Stalls the CPU through a pause handshake, grants the RAM to the hiscore engine, then returns it to the CPU.
- Merges the user and OSD pause sources into the same CPU pause line.
- Generates the video-dim flag after a long pause.
- Sits between the hiscore module, mario_top's CPU/RAM path and the video output stage.

Parameters:
- AW, 11, work RAM address width.
- DIM_CYCLES, 480000000, continuous paused cycles before O_DIM is set (10 s at 48 MHz).
- ACK_TIMEOUT, 4096, cycles to wait for the CPU pause acknowledge before aborting a hiscore request.

Ports:
- I_CLK_48M  in  1  system clock.
- I_RESETn  in  1  reset, asynchronous, active-low.
- I_USER_PAUSE  in  1  user pause level (toggle already resolved upstream).
- I_OSD_PAUSE  in  1  OSD-open pause level (already gated by menu option).
- I_HS_REQ  in  1  hiscore engine requests RAM ownership (level).
- I_HS_ADDR  in  AW  hiscore address.
- I_HS_DIN  in  8  hiscore write data.
- I_HS_WE  in  1  hiscore write strobe.
- I_HS_RD  in  1  hiscore read strobe.
- O_HS_GNT  out  1  RAM owned by hiscore engine.
- O_HS_DOUT  out  8  registered read data.
- O_HS_RVALID  out  1  read data valid pulse.
- O_HS_ABORT  out  1  one-cycle pulse: request aborted on timeout.
- I_CPU_ADDR  in  AW  CPU address.
- I_CPU_DIN  in  8  CPU write data.
- I_CPU_WE  in  1  CPU write strobe.
- O_CPU_PAUSE  out  1  CPU stall request.
- I_CPU_PAUSED  in  1  CPU stalled at a safe bus boundary.
- O_RAM_ADDR  out  AW  muxed RAM address.
- O_RAM_DOUT  out  8  muxed RAM write data.
- O_RAM_WE  out  1  muxed RAM write enable.
- I_RAM_DIN  in  8  RAM read data (synchronous RAM, 1-cycle latency).
- O_DIM  out  1  dim video.

Behaviour:
- Reset (async assert, sync release): state IDLE; O_HS_GNT, O_HS_RVALID, O_HS_ABORT, O_CPU_PAUSE, O_DIM all 0; O_HS_DOUT 0; timers 0. Reset mid-grant returns the RAM to the CPU immediately.
- States and transitions:
  - IDLE: I_HS_REQ=1 -> STALL, timeout counter cleared.
  - STALL: I_HS_REQ=0 -> IDLE. I_CPU_PAUSED=1 -> GRANT. Counter reaches ACK_TIMEOUT-1 -> ABORT.
  - GRANT: O_HS_GNT=1; stays while I_HS_REQ=1; I_HS_REQ=0 -> DRAIN.
  - DRAIN: exactly 1 cycle; O_HS_GNT=0, CPU still paused so the last hiscore access completes; -> IDLE.
  - ABORT: O_HS_ABORT=1 for exactly 1 cycle; -> WAITLOW.
  - WAITLOW: waits for I_HS_REQ=0, then -> IDLE. A held request is never retried.
- O_CPU_PAUSE = I_USER_PAUSE | I_OSD_PAUSE | (state in STALL, GRANT, DRAIN); registered. If a user/OSD pause is already active and the CPU is acked, STALL->GRANT takes 1 cycle.
- RAM mux is combinational on registered O_HS_GNT:
  - gnt=1: addr/data from hiscore; WE = I_HS_WE.
  - gnt=0: addr/data/WE from CPU.
  - I_HS_WE/I_HS_RD are ignored while gnt=0.
- Read: I_HS_RD=1 with gnt=1 in cycle N -> O_HS_DOUT=I_RAM_DIN and O_HS_RVALID=1 in cycle N+1, for one cycle. Back-to-back reads are allowed every cycle.
- Simultaneous I_HS_WE and I_HS_RD: write wins; no RVALID.
- Dim timer:
  - Counts while O_CPU_PAUSE=1 and saturates at DIM_CYCLES.
  - O_DIM=1 when count >= DIM_CYCLES.
  - Cleared to 0 the cycle after O_CPU_PAUSE falls.
  - Width is ceil(log2(DIM_CYCLES+1)).
- If I_CPU_PAUSED drops during GRANT, the grant is held anyway. The CPU must not resume while O_CPU_PAUSE=1; this is a protocol violation flagged by a bench assertion.

Decomposition:
- Shared package mario_pkg holds:
  - state enum hs_arb_state_t {IDLE, STALL, GRANT, DRAIN, ABORT, WAITLOW};
  - DIM_CYCLES_48M constant;
  - hiscore RAM width constants.
- One sub-module, pause_dim_timer: saturating counter with clear, parameterised by DIM_CYCLES. Instantiated once.

Test Plan:
- Basic grant: HS_REQ rises, CPU acks 3 cycles later. Expect:
  - CPU_PAUSE=1 the cycle after the request;
  - GNT=1 the cycle after the ack;
  - RAM_ADDR follows HS_ADDR (0x1A5) while granted.
  After HS_REQ drops: GNT=0 next cycle, CPU_PAUSE=0 one cycle later.
- Read/write: granted, write 0x3C to 0x040, then read 0x040 with RAM model. Expect RAM_WE=1 in the write cycle and RVALID=1 with DOUT=0x3C exactly one cycle after RD.
- Timeout: ACK_TIMEOUT=16, hold HS_REQ, never ack. Expect ABORT pulse on cycle 17 after entry to STALL, GNT never 1, CPU_PAUSE=0 afterwards, no re-request until HS_REQ is cycled low-high.
- Pre-paused: USER_PAUSE=1 and PAUSED=1, then HS_REQ. Expect GNT 2 cycles after HS_REQ; CPU_PAUSE stays 1 after HS_REQ drops.
- Dim: DIM_CYCLES=100, OSD_PAUSE held. Expect DIM=0 at count 99 and DIM=1 at count 100, held high. Drop OSD_PAUSE: DIM=0 within 2 cycles.
- Reset mid-GRANT: pulse I_RESETn low asynchronously. Expect GNT, CPU_PAUSE, DIM, RVALID=0 immediately and RAM_ADDR = CPU_ADDR.
